// File: rtl/window_buffer_7x7_pkg.sv
// Shared widths and pixel type for the 7x7 window front end.
package my_package;
  localparam int PIX_W  = 8;
  localparam int WIN    = 7;
  localparam int LINE_W = WIN * PIX_W;

  typedef logic [PIX_W-1:0] pixel_t;
endpackage

// File: rtl/window_buffer_7x7_line_delay.sv
// One image line of pixel history: a DEPTH-deep circular buffer that moves
// only on en_i. dout_o is the pixel written DEPTH enables ago, read
// combinationally so a chain of these forms a multi-line tap.
module line_delay
  import my_package::*;
#(
  parameter int DEPTH = 640
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en_i,
  input  pixel_t din_i,
  output pixel_t dout_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pixel_t          mem_q [DEPTH];
  logic   [PW-1:0] ptr_q;

  // Storage is left unreset; the window validity logic never exposes stale data.
  always_ff @(posedge clk) begin
    if (en_i) mem_q[ptr_q] <= din_i;
  end

  // Single read/write pointer wrapping at DEPTH-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    ptr_q <= '0;
    else if (en_i) ptr_q <= (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  end

  assign dout_o = mem_q[ptr_q];
endmodule

// File: rtl/window_buffer_7x7.sv
// Raster pixel stream to sliding 7x7 window. Six chained line delays supply
// the upper rows; the window shifts left one pixel per accepted input and
// de_out marks windows lying entirely inside the current frame.
module window_buffer_7x7
  import my_package::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sof_in,
  input  logic              de_in,
  input  logic [PIX_W-1:0]  pixel_in,
  output logic [LINE_W-1:0] line_0_out,
  output logic [LINE_W-1:0] line_1_out,
  output logic [LINE_W-1:0] line_2_out,
  output logic [LINE_W-1:0] line_3_out,
  output logic [LINE_W-1:0] line_4_out,
  output logic [LINE_W-1:0] line_5_out,
  output logic [LINE_W-1:0] line_6_out,
  output logic              de_out
);
  localparam int         CW      = $clog2(IMG_WIDTH);
  // Row only needs to reach WIN-1; a shorter image would saturate earlier.
  localparam logic [2:0] ROW_SAT = (IMG_HEIGHT > WIN - 1) ? 3'(WIN - 1) : 3'(IMG_HEIGHT - 1);

  logic                         acc;
  logic [CW-1:0]                col_q, col_d, col_pos;
  logic [2:0]                   row_q, row_d, row_pos;
  logic                         locked_q, locked_d;
  logic                         de_q, de_d;
  logic [WIN-1:0][LINE_W-1:0]   win_q;
  pixel_t                       dl_in  [WIN-1];
  pixel_t                       dl_out [WIN-1];
  pixel_t                       nb     [WIN];

  // Acceptance, position of the current pixel and next counter state.
  always_comb begin
    acc      = de_in & (locked_q | sof_in);
    col_pos  = sof_in ? '0 : col_q;
    row_pos  = sof_in ? '0 : row_q;
    locked_d = locked_q | (de_in & sof_in);
    col_d    = col_q;
    row_d    = row_q;
    de_d     = 1'b0;
    if (acc) begin
      de_d = (row_pos >= 3'(WIN - 1)) && (col_pos >= CW'(WIN - 1));
      if (col_pos == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_pos == ROW_SAT) ? row_pos : row_pos + 3'd1;
      end else begin
        col_d = col_pos + 1'b1;
        row_d = row_pos;
      end
    end
  end

  // Counters, lock flag and window strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q    <= '0;
      row_q    <= '0;
      locked_q <= 1'b0;
      de_q     <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      locked_q <= locked_d;
      de_q     <= de_d;
    end
  end

  // Delay-line chain: dl_out[i] is the pixel (i+1) lines back, feeding row WIN-2-i.
  assign nb[WIN-1] = pixel_in;
  for (genvar i = 0; i < WIN - 1; i++) begin : g_dl
    if (i == 0) begin : g_first
      assign dl_in[i] = pixel_in;
    end else begin : g_next
      assign dl_in[i] = dl_out[i-1];
    end
    line_delay #(.DEPTH(IMG_WIDTH)) u_dl (
      .clk    (clk),
      .reset  (reset),
      .en_i   (acc),
      .din_i  (dl_in[i]),
      .dout_o (dl_out[i])
    );
    assign nb[WIN-2-i] = dl_out[i];
  end

  // Window rows shift left one pixel on each accepted input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q <= '0;
    end else if (acc) begin
      for (int k = 0; k < WIN; k++)
        win_q[k] <= {win_q[k][LINE_W-PIX_W-1:0], nb[k]};
    end
  end

  assign line_0_out = win_q[0];
  assign line_1_out = win_q[1];
  assign line_2_out = win_q[2];
  assign line_3_out = win_q[3];
  assign line_4_out = win_q[4];
  assign line_5_out = win_q[5];
  assign line_6_out = win_q[6];
  assign de_out     = de_q;
endmodule

// File: tb/tb_window_buffer_7x7.sv
// Randomized scoreboard bench for window_buffer_7x7 on an 8x8 image.
module tb_window_buffer_7x7;
  localparam int W = 8;
  localparam int H = 8;

  typedef logic [6:0][55:0] win_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sof_in = 1'b0;
  logic        de_in = 1'b0;
  logic [7:0]  pixel_in = 8'h00;
  logic [55:0] line_0_out, line_1_out, line_2_out, line_3_out, line_4_out, line_5_out, line_6_out;
  logic        de_out;

  window_buffer_7x7 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .sof_in(sof_in), .de_in(de_in), .pixel_in(pixel_in),
    .line_0_out(line_0_out), .line_1_out(line_1_out), .line_2_out(line_2_out),
    .line_3_out(line_3_out), .line_4_out(line_4_out), .line_5_out(line_5_out),
    .line_6_out(line_6_out), .de_out(de_out)
  );

  always #5 clk = ~clk;

  win_t cur;
  assign cur = {line_6_out, line_5_out, line_4_out, line_3_out, line_2_out, line_1_out, line_0_out};

  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;
  win_t exp_q[$];

  // reference model: frame image plus position, computed from the raster rules
  logic [7:0] img [0:15][0:W-1];
  bit         m_locked = 0;
  int         m_r = 0, m_c = 0;

  bit          first_pending = 0;
  logic [55:0] first_l0, first_l6;

  task automatic check(string name, logic [55:0] act, logic [55:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic model_accept(logic [7:0] pix, bit sof);
    win_t e;
    if (!(sof || m_locked)) return;
    if (sof) begin m_locked = 1; m_r = 0; m_c = 0; end
    img[m_r][m_c] = pix;
    if (m_r >= 6 && m_c >= 6) begin
      for (int k = 0; k < 7; k++)
        for (int j = 0; j < 7; j++)
          e[k][55-8*j -: 8] = img[m_r-6+k][m_c-6+j];
      exp_q.push_back(e);
    end
    m_c++;
    if (m_c == W) begin m_c = 0; if (m_r < 15) m_r++; end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    de_in = 1'b0; sof_in = 1'($urandom); pixel_in = 8'($urandom);
  endtask

  task automatic send(logic [7:0] pix, bit sof, int gap);
    repeat (gap) idle();
    @(posedge clk); #1;
    de_in = 1'b1; sof_in = sof; pixel_in = pix;
    model_accept(pix, sof);
  endtask

  task automatic send_pixels(int first, int n, bit with_sof, bit gaps, bit rnd);
    for (int i = first; i < first + n; i++) begin
      logic [3:0] r, c;
      logic [7:0] pix;
      r = 4'(i / W); c = 4'(i % W);
      pix = rnd ? 8'($urandom) : {r, c};
      send(pix, with_sof && (i == first), gaps ? int'($urandom_range(0, 1)) * int'($urandom_range(1, 5)) : 0);
    end
    idle();
  endtask

  task automatic full_frame(string name, bit gaps, bit rnd, bit chk_first);
    int p0;
    p0 = pulses;
    first_pending = chk_first;
    send_pixels(0, W * H, 1, gaps, rnd);
    repeat (3) idle();
    check({name, "_pulses"}, 56'(pulses - p0), 56'd4);
    if (chk_first) begin
      check({name, "_first_l0"}, first_l0, 56'h00010203040506);
      check({name, "_first_l6"}, first_l6, 56'h60616263646566);
    end
  endtask

  // monitor: pop scoreboard on each de_out and compare the window
  always @(negedge clk) begin
    if (reset && de_out) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_de_out got=1 want=0 l0=%h", line_0_out);
      end else begin
        win_t e;
        e = exp_q.pop_front();
        for (int k = 0; k < 7; k++) check($sformatf("win_line%0d", k), cur[k], e[k]);
        if (first_pending) begin
          first_l0 = line_0_out; first_l6 = line_6_out; first_pending = 0;
        end
      end
    end
  end

  // stall monitor: an edge with de_in low must leave every output unchanged
  logic de_s = 1'b0, rst_s = 1'b0;
  win_t snap;
  bit   snap_ok = 0;
  always @(posedge clk) begin
    de_s  <= de_in;
    rst_s <= reset;
  end
  always @(negedge clk) begin
    if (rst_s && reset && !de_s && snap_ok) begin
      checks++;
      if (cur !== snap || de_out !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold got=%h de=%b want=%h de=0", cur, de_out, snap);
      end
    end
    snap = cur;
    snap_ok = reset;
  end

  initial begin
    // 1: reset held with toggling pixels
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      de_in = 1'(i); sof_in = 1'($urandom); pixel_in = 8'($urandom);
      @(negedge clk);
      check("rst_line0", line_0_out, 56'h0);
      check("rst_line6", line_6_out, 56'h0);
      check("rst_de", 56'(de_out), 56'h0);
    end
    @(posedge clk); #1;
    de_in = 1'b0; sof_in = 1'b0;
    reset = 1'b1;

    // 4: pixels before any sof are ignored
    begin
      int p0;
      p0 = pulses;
      send_pixels(0, 60, 0, 1, 0);
      repeat (3) idle();
      check("nolock_pulses", 56'(pulses - p0), 56'd0);
    end

    // 2: continuous frame with the {row,col} pattern
    full_frame("frame_cont", 0, 0, 1);
    // 3: same frame with bubbles
    full_frame("frame_bubble", 1, 0, 1);
    // random data, random bubbles
    full_frame("frame_rand", 1, 1, 0);
    full_frame("frame_rand2", 0, 1, 0);

    // 5: sof restarts the frame at (3,4)
    begin
      int p0;
      p0 = pulses;
      send_pixels(0, 3 * W + 4, 1, 1, 0);
      check("midsof_pulses_pre", 56'(pulses - p0), 56'd0);
      full_frame("midsof", 1, 0, 1);
    end

    // 6: reset pulsed at pixel (6,7)
    begin
      int p0;
      send_pixels(0, 6 * W + 7, 1, 0, 0);
      send(8'h67, 0, 0);
      @(posedge clk); #1;
      check("pre_rst_de", 56'(de_out), 56'd1);
      reset = 1'b0;
      exp_q.delete();
      m_locked = 0;
      #1;
      check("async_rst_de", 56'(de_out), 56'd0);
      check("async_rst_l6", line_6_out, 56'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      p0 = pulses;
      send_pixels(0, 16, 0, 1, 0);
      repeat (3) idle();
      check("post_rst_nolock", 56'(pulses - p0), 56'd0);
      full_frame("post_rst", 0, 0, 1);
    end

    repeat (4) idle();
    check("queue_empty", 56'(exp_q.size()), 56'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
